// File: rtl/wired0_defines.sv
// Shared pipeline types between the frontend and backend.
package wired0_defines;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        wen;
   } pipeline_ctrl_pack_t;

endpackage

// File: rtl/wired_frontend_pkg_queue_pkg.sv
// Constants and helpers for the frontend packet queue.
package wired_frontend_pkg_queue_pkg;

   localparam int unsigned SLOTS = 2;

   function automatic logic [1:0] popcnt2(input logic [1:0] m);
      return {1'b0, m[0]} + {1'b0, m[1]};
   endfunction

endpackage

// File: rtl/wired_pkg_slot_ram.sv
// Flop array holding queued instructions: two write ports, two combinational read ports.
module wired_pkg_slot_ram
   import wired0_defines::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       we0,
   input  logic [$clog2(DEPTH)-1:0]   waddr0,
   input  pipeline_ctrl_pack_t        wdata0,
   input  logic                       we1,
   input  logic [$clog2(DEPTH)-1:0]   waddr1,
   input  pipeline_ctrl_pack_t        wdata1,
   input  logic [$clog2(DEPTH)-1:0]   raddr0,
   output pipeline_ctrl_pack_t        rdata0,
   input  logic [$clog2(DEPTH)-1:0]   raddr1,
   output pipeline_ctrl_pack_t        rdata1
);

   pipeline_ctrl_pack_t mem [DEPTH];

   // Storage is intentionally not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/wired_frontend_pkg_queue.sv
// Frontend decoupling queue: stores decoded slots individually and issues compacted
// in-order 2-wide packets to rename.
module wired_frontend_pkg_queue
   import wired0_defines::*;
   import wired_frontend_pkg_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush_i,
   input  logic                             dec_valid_i,
   output logic                             dec_ready_o,
   input  logic [SLOTS-1:0]                 dec_mask_i,
   input  pipeline_ctrl_pack_t [SLOTS-1:0]  dec_i,
   output logic                             pkg_valid_o,
   input  logic                             pkg_ready_i,
   output logic [SLOTS-1:0]                 pkg_mask_o,
   output pipeline_ctrl_pack_t [SLOTS-1:0]  pkg_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                accept;
   logic                pop;
   logic [1:0]          push_n, pop_n;
   logic                we0, we1;
   logic [PTR_W-1:0]    waddr0, waddr1;
   pipeline_ctrl_pack_t wdata0, wdata1;
   pipeline_ctrl_pack_t rdata0, rdata1;

   // Based on registered count only, so a same-cycle pop never raises ready.
   assign dec_ready_o = !flush_i && (count_q <= CNT_W'(DEPTH - 2));
   assign accept      = dec_valid_i && dec_ready_o;

   always_comb begin
      we0    = 1'b0;
      we1    = 1'b0;
      waddr0 = tail_q;
      waddr1 = tail_q + PTR_W'(1);
      wdata0 = dec_i[0];
      wdata1 = dec_i[1];
      push_n = 2'd0;
      if (accept) begin
         unique case (dec_mask_i)
            2'b11: begin
               we0    = 1'b1;
               we1    = 1'b1;
               push_n = 2'd2;
            end
            2'b01: begin
               we0    = 1'b1;
               push_n = 2'd1;
            end
            2'b10: begin
               // Lone slot 1 is compacted into the tail entry.
               we0    = 1'b1;
               wdata0 = dec_i[1];
               push_n = 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pkg_valid_o = (count_q != '0) && !flush_i;
      pkg_mask_o  = 2'b00;
      if (pkg_valid_o) pkg_mask_o = (count_q >= CNT_W'(2)) ? 2'b11 : 2'b01;
      pkg_o[0]    = pkg_mask_o[0] ? rdata0 : '0;
      pkg_o[1]    = pkg_mask_o[1] ? rdata1 : '0;
      pop         = pkg_valid_o && pkg_ready_i;
      pop_n       = pop ? popcnt2(pkg_mask_o) : 2'd0;
   end

   always_comb begin
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(pop_n);
         tail_d  = tail_q + PTR_W'(push_n);
         count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   wired_pkg_slot_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .raddr0 (head_q),
      .rdata0 (rdata0),
      .raddr1 (head_q + PTR_W'(1)),
      .rdata1 (rdata1)
   );

endmodule

// File: tb/tb_wired_frontend_pkg_queue.sv
// Directed bench for the frontend packet queue with an in-order scoreboard.
module tb_wired_frontend_pkg_queue;
   import wired0_defines::*;

   localparam int unsigned DEPTH = 8;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      flush_i;
   logic                      dec_valid_i;
   logic                      dec_ready_o;
   logic [1:0]                dec_mask_i;
   pipeline_ctrl_pack_t [1:0] dec_i;
   logic                      pkg_valid_o;
   logic                      pkg_ready_i;
   logic [1:0]                pkg_mask_o;
   pipeline_ctrl_pack_t [1:0] pkg_o;

   pipeline_ctrl_pack_t sb [$];
   int vectors    = 0;
   int miscompares = 0;
   int next_id    = 0;

   always #5 clk = ~clk;

   wired_frontend_pkg_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .dec_valid_i (dec_valid_i),
      .dec_ready_o (dec_ready_o),
      .dec_mask_i  (dec_mask_i),
      .dec_i       (dec_i),
      .pkg_valid_o (pkg_valid_o),
      .pkg_ready_i (pkg_ready_i),
      .pkg_mask_o  (pkg_mask_o),
      .pkg_o       (pkg_o)
   );

   function automatic pipeline_ctrl_pack_t mk();
      pipeline_ctrl_pack_t p;
      p.pc    = 32'h1000 + 32'(next_id) * 4;
      p.instr = $urandom;
      p.rd    = 5'($urandom);
      p.wen   = 1'($urandom);
      next_id++;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare outputs against the model at negedge, then retire pops and record pushes.
   task automatic sample();
      logic                exp_ready, exp_valid;
      logic [1:0]          exp_mask;
      pipeline_ctrl_pack_t e0, e1;
      int                  n;
      if (rst) begin
         sb.delete();
         return;
      end
      n         = sb.size();
      exp_ready = !flush_i && (n <= DEPTH - 2);
      exp_valid = (n != 0) && !flush_i;
      exp_mask  = !exp_valid ? 2'b00 : (n >= 2) ? 2'b11 : 2'b01;
      e0        = exp_mask[0] ? sb[0] : '0;
      e1        = exp_mask[1] ? sb[1] : '0;
      chk("dec_ready", 128'(dec_ready_o), 128'(exp_ready));
      chk("pkg_valid", 128'(pkg_valid_o), 128'(exp_valid));
      chk("pkg_mask",  128'(pkg_mask_o),  128'(exp_mask));
      chk("pkg_slot0", 128'(pkg_o[0]),    128'(e0));
      chk("pkg_slot1", 128'(pkg_o[1]),    128'(e1));
      if (flush_i) begin
         sb.delete();
         return;
      end
      if (exp_valid && pkg_ready_i) begin
         void'(sb.pop_front());
         if (exp_mask[1]) void'(sb.pop_front());
      end
      if (dec_valid_i && exp_ready) begin
         if (dec_mask_i[0]) sb.push_back(dec_i[0]);
         if (dec_mask_i[1]) sb.push_back(dec_i[1]);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      flush_i     = 1'b0;
      dec_valid_i = 1'b0;
      dec_mask_i  = 2'b00;
      dec_i       = '0;
      pkg_ready_i = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Pair then single, backend ready afterwards.
      dec_valid_i = 1'b1;
      dec_mask_i  = 2'b11;
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      tick();
      dec_mask_i  = 2'b01;
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      tick();
      dec_valid_i = 1'b0;
      pkg_ready_i = 1'b1;
      repeat (3) tick();

      // Compaction of lone slots while stalled.
      pkg_ready_i = 1'b0;
      dec_valid_i = 1'b1;
      dec_mask_i  = 2'b10;
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      tick();
      dec_mask_i  = 2'b01;
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      tick();
      dec_valid_i = 1'b0;
      tick();
      pkg_ready_i = 1'b1;
      tick();
      pkg_ready_i = 1'b0;
      tick();

      // Fill to full, then one pop of two.
      dec_valid_i = 1'b1;
      dec_mask_i  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         dec_i[0] = mk();
         dec_i[1] = mk();
         tick();
      end
      dec_valid_i = 1'b0;
      tick();
      pkg_ready_i = 1'b1;
      tick();
      pkg_ready_i = 1'b0;
      tick();
      pkg_ready_i = 1'b1;
      repeat (4) tick();

      // Streaming with random masks across several wraps.
      dec_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         dec_mask_i = 2'($urandom_range(0, 3));
         dec_i[0]   = mk();
         dec_i[1]   = mk();
         tick();
      end
      dec_valid_i = 1'b0;
      repeat (6) tick();

      // Flush with count=5 and competing handshakes.
      pkg_ready_i = 1'b0;
      dec_valid_i = 1'b1;
      dec_mask_i  = 2'b11;
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      tick();
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      tick();
      dec_mask_i  = 2'b01;
      dec_i[0]    = mk();
      tick();
      flush_i     = 1'b1;
      dec_mask_i  = 2'b11;
      dec_i[0]    = mk();
      dec_i[1]    = mk();
      pkg_ready_i = 1'b1;
      tick();
      flush_i     = 1'b0;
      dec_valid_i = 1'b0;
      repeat (2) tick();

      // Reset in the middle of traffic.
      pkg_ready_i = 1'b0;
      dec_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dec_i[0] = mk();
         dec_i[1] = mk();
         tick();
      end
      rst         = 1'b1;
      pkg_ready_i = 1'b1;
      tick();
      rst         = 1'b0;
      dec_valid_i = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
